lcd_char_responder: RTL

LCD_CHAR_RESPONDER -- requirements
Module: lcd_char_responder

---
 rtl/lcd_char_if.sv | 19 +
 rtl/lcd_char_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lcd_char_if.sv
// lcd_char_if: host-side character LCD parallel bus.
// The host drives E/RS/RW/DB; the display returns the read bus.
interface lcd_char_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic [7:0] lcd_q;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, lcd_data,
        input  lcd_q
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, lcd_data,
        output lcd_q
    );
endinterface

// File: rtl/lcd_char_responder.sv
// lcd_char_responder: HD44780-style character display target.
// Synchronizes the host bus, executes on E falling, holds a 2x16 DDRAM.
module lcd_char_responder #(
    parameter int BUSY_CMD    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    lcd_char_if.slave  bus,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink,
    output logic       lines2,
    output logic       busy,
    output logic [7:0] ign_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    state_t                 state_q;
    logic [7:0]             mem_q [32];
    logic [SYNC_STAGES-1:0] e_sq, rs_sq, rw_sq;
    logic [7:0]             d_sq [SYNC_STAGES];
    logic                   e_prev_q;
    logic [6:0]             ac_q, ac_d;
    logic                   id_q, disp_q, cur_q;
    logic                   blink_q, lines2_q, busy_q;
    logic [7:0]             cnt_q, ign_q, lcdq_q;
    logic [4:0]             clr_q, ac_idx;
    logic                   e_s, rs_s, rw_s, fall;
    logic [7:0]             d_s;
    logic                   unused_rd;

    // Line 1 ends at 0x0F and line 2 at 0x4F; stepping wraps between them.
    function automatic logic [6:0] ac_step(
        input logic [6:0] a,
        input logic       inc
    );
        if (inc) begin
            if (a == 7'h0F) return 7'h40;
            if (a == 7'h4F) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h4F;
        if (a == 7'h40) return 7'h0F;
        return a - 7'd1;
    endfunction

    assign e_s       = e_sq[SYNC_STAGES-1];
    assign rs_s      = rs_sq[SYNC_STAGES-1];
    assign rw_s      = rw_sq[SYNC_STAGES-1];
    assign d_s       = d_sq[SYNC_STAGES-1];
    assign fall      = e_prev_q & ~e_s;
    assign ac_idx    = {ac_q[6], ac_q[3:0]};
    assign ac_d      = ac_step(ac_q, id_q);
    assign rd_data   = mem_q[{rd_addr[6], rd_addr[3:0]}];
    assign unused_rd = ^rd_addr[5:4];

    assign bus.lcd_q   = lcdq_q;
    assign cursor_addr = ac_q;
    assign disp_on     = disp_q;
    assign cursor_on   = cur_q;
    assign blink       = blink_q;
    assign lines2      = lines2_q;
    assign busy        = busy_q;
    assign ign_cnt     = ign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            e_sq     <= '0;
            rs_sq    <= '0;
            rw_sq    <= '0;
            e_prev_q <= 1'b0;
            ac_q     <= '0;
            id_q     <= 1'b1;
            disp_q   <= 1'b0;
            cur_q    <= 1'b0;
            blink_q  <= 1'b0;
            lines2_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            ign_q    <= '0;
            lcdq_q   <= '0;
            clr_q    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++)
                d_sq[i] <= '0;
            for (int i = 0; i < 32; i++)
                mem_q[i] <= 8'h20;
        end else begin
            e_sq  <= {e_sq[SYNC_STAGES-2:0], bus.lcd_e};
            rs_sq <= {rs_sq[SYNC_STAGES-2:0], bus.lcd_rs};
            rw_sq <= {rw_sq[SYNC_STAGES-2:0], bus.lcd_rw};
            d_sq[0] <= bus.lcd_data;
            for (int i = 1; i < SYNC_STAGES; i++)
                d_sq[i] <= d_sq[i-1];
            e_prev_q <= e_s;

            if (!rw_s)
                lcdq_q <= 8'h00;
            else if (rs_s)
                lcdq_q <= mem_q[ac_idx];
            else
                lcdq_q <= {busy_q, ac_q};

            unique case (state_q)
                IDLE: begin
                    if (fall && !rw_s) begin
                        if (!rs_s && d_s == 8'h01) begin
                            state_q <= CLEAR;
                            clr_q   <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            if (rs_s) begin
                                mem_q[ac_idx] <= d_s;
                                ac_q          <= ac_d;
                            end else if (d_s[7]) begin
                                ac_q <= {d_s[6], 2'b00, d_s[3:0]};
                            end else if (d_s[6]) begin
                                ac_q <= ac_q;
                            end else if (d_s[5]) begin
                                lines2_q <= d_s[3];
                            end else if (d_s[4]) begin
                                if (!d_s[3])
                                    ac_q <= ac_step(ac_q, d_s[2]);
                            end else if (d_s[3]) begin
                                disp_q  <= d_s[2];
                                cur_q   <= d_s[1];
                                blink_q <= d_s[0];
                            end else if (d_s[2]) begin
                                id_q <= d_s[1];
                            end else if (d_s[1]) begin
                                ac_q <= '0;
                            end
                            if (BUSY_CMD != 0) begin
                                state_q <= EXEC;
                                cnt_q   <= 8'(BUSY_CMD);
                                busy_q  <= 1'b1;
                            end
                        end
                    end else if (fall && rs_s) begin
                        ac_q <= ac_d;
                    end
                end
                EXEC: begin
                    if (fall && !rw_s && ign_q != 8'hFF)
                        ign_q <= ign_q + 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                CLEAR: begin
                    if (fall && !rw_s && ign_q != 8'hFF)
                        ign_q <= ign_q + 8'd1;
                    mem_q[clr_q] <= 8'h20;
                    clr_q        <= clr_q + 5'd1;
                    if (clr_q == 5'd31) begin
                        ac_q    <= '0;
                        id_q    <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
